// File: rtl/shift_counter_pkg.sv
// Shared constants and lock-FSM state type for the Johnson shift counter
// and its receive-side decoder.
package shift_counter_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_IDX_W      = $clog2(2 * DEF_WIDTH);
  localparam int DEF_LOCK_COUNT = 3;
  localparam int DEF_ERR_W      = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/shift_counter_decoder_johnson_decode.sv
// Combinational Johnson-code decoder: legality check plus conversion of a
// code word back to its position in the 2*WIDTH-state sequence.
module johnson_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  localparam int CW = IDX_W + 1;

  logic [WIDTH-2:0] edge_bits;
  logic [CW-1:0]    ones;
  logic [CW-1:0]    edges;

  // A legal code has at most one boundary between its run of 0s and 1s.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
      assign edge_bits[gi] = code[gi] ^ code[gi+1];
    end
  endgenerate

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(code[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + CW'(edge_bits[i]);
    end
  end

  assign legal = (edges <= CW'(1));
  assign index = code[WIDTH-1] ? IDX_W'(2 * WIDTH - int'(ones)) : IDX_W'(ones);

endmodule

// File: rtl/shift_counter_decoder.sv
// Receive-side Johnson code checker: decodes the sampled code, tracks
// sequence lock with a HUNT/CHECK/LOCKED FSM and counts error events.
module shift_counter_decoder
  import shift_counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IDX_W      = $clog2(2 * WIDTH),
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code,
  input  logic             code_vld,
  output logic [IDX_W-1:0] index,
  output logic             index_vld,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int NSTATES = 2 * WIDTH;
  localparam int RUN_W   = $clog2(LOCK_COUNT + 1);

  logic             dec_legal;
  logic [IDX_W-1:0] dec_index;

  lock_state_t      state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [IDX_W-1:0] prev_idx_reg, prev_idx_next, prev_inc;
  logic [IDX_W-1:0] index_reg, index_next;
  logic             index_vld_reg, index_vld_next;
  logic             illegal_reg, illegal_next;
  logic             seq_err_reg, seq_err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic             same, next_ok, lose_lock;

  johnson_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .code  (code),
    .legal (dec_legal),
    .index (dec_index)
  );

  // Explicit wrap so non-power-of-two sequence lengths still compare correctly.
  assign prev_inc = (prev_idx_reg == IDX_W'(NSTATES - 1)) ? '0 : prev_idx_reg + IDX_W'(1);
  assign same     = (dec_index == prev_idx_reg);
  assign next_ok  = (dec_index == prev_inc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= HUNT;
      run_reg      <= '0;
      prev_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      run_reg      <= run_next;
      prev_idx_reg <= prev_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    run_next      = run_reg;
    prev_idx_next = prev_idx_reg;
    lose_lock     = 1'b0;
    if (code_vld) begin
      if (!dec_legal) begin
        lose_lock  = (state_reg == LOCKED);
        state_next = HUNT;
        run_next   = '0;
      end else begin
        prev_idx_next = dec_index;
        case (state_reg)
          HUNT: begin
            state_next = CHECK;
            run_next   = RUN_W'(1);
          end
          CHECK: begin
            // A repeated index is a stalled counter and leaves the run untouched.
            if (!same) begin
              if (next_ok) begin
                run_next = run_reg + RUN_W'(1);
                if (run_reg == RUN_W'(LOCK_COUNT - 1)) begin
                  state_next = LOCKED;
                end
              end else begin
                run_next = RUN_W'(1);
              end
            end
          end
          LOCKED: begin
            if (!(same || next_ok)) begin
              lose_lock  = 1'b1;
              state_next = HUNT;
              run_next   = '0;
            end
          end
          default: begin
            state_next = HUNT;
            run_next   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    illegal_next   = code_vld && !dec_legal;
    index_vld_next = code_vld && dec_legal;
    seq_err_next   = lose_lock;
    index_next     = index_vld_next ? dec_index : index_reg;
    err_cnt_next   = err_cnt_reg;
    // Simultaneous illegal and seq_err are one event.
    if ((illegal_next || seq_err_next) && (err_cnt_reg != '1)) begin
      err_cnt_next = err_cnt_reg + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      index_reg     <= '0;
      index_vld_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      seq_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      index_reg     <= index_next;
      index_vld_reg <= index_vld_next;
      illegal_reg   <= illegal_next;
      seq_err_reg   <= seq_err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign index     = index_reg;
  assign index_vld = index_vld_reg;
  assign illegal   = illegal_reg;
  assign seq_err   = seq_err_reg;
  assign locked    = (state_reg == LOCKED);
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_shift_counter_decoder.sv
// Randomised and directed bench for shift_counter_decoder with a table-driven
// reference model compared against the DUT on every falling edge.
module tb_shift_counter_decoder;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int LC = 3;
  localparam int EW = 8;
  localparam int NS = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  code = '0;
  logic          code_vld = 1'b0;
  logic [IW-1:0] index;
  logic          index_vld, illegal, seq_err, locked;
  logic [EW-1:0] err_cnt;

  shift_counter_decoder #(
    .WIDTH      (W),
    .IDX_W      (IW),
    .LOCK_COUNT (LC),
    .ERR_W      (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .code      (code),
    .code_vld  (code_vld),
    .index     (index),
    .index_vld (index_vld),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Model state: mode 0=hunting, 1=checking, 2=locked.
  int m_index = 0, m_prev = 0, m_mode = 0, m_run = 0, m_err = 0;
  bit m_vld = 0, m_ill = 0, m_seq = 0;
  bit model_ready = 0;

  // The k-th code of the sequence: k ones filling from the LSB, then k-W
  // zeros filling from the LSB.
  function automatic logic [W-1:0] code_of(int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
    return v[W-1:0];
  endfunction

  function automatic int lookup(logic [W-1:0] c);
    for (int k = 0; k < NS; k++) begin
      if (code_of(k) == c) return k;
    end
    return -1;
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(bit r, logic [W-1:0] c, bit v);
    int  k;
    bit  nxt, same;
    m_vld = 0; m_ill = 0; m_seq = 0;
    if (!r) begin
      m_index = 0; m_prev = 0; m_mode = 0; m_run = 0; m_err = 0;
      return;
    end
    if (!v) return;
    k = lookup(c);
    if (k < 0) begin
      m_ill = 1;
      if (m_mode == 2) m_seq = 1;
      m_mode = 0;
      m_run  = 0;
    end else begin
      m_vld   = 1;
      m_index = k;
      nxt  = (k == (m_prev + 1) % NS);
      same = (k == m_prev);
      if (m_mode == 0) begin
        m_mode = 1;
        m_run  = 1;
      end else if (m_mode == 1) begin
        if (!same) begin
          if (nxt) begin
            m_run++;
            if (m_run == LC) m_mode = 2;
          end else begin
            m_run = 1;
          end
        end
      end else if (!(same || nxt)) begin
        m_seq  = 1;
        m_mode = 0;
        m_run  = 0;
      end
      m_prev = k;
    end
    if ((m_ill || m_seq) && m_err < (1 << EW) - 1) m_err++;
  endtask

  task automatic step(bit r, logic [W-1:0] c, bit v);
    @(negedge clk);
    reset = r; code = c; code_vld = v;
    @(posedge clk);
    model_update(r, c, v);
    model_ready = 1;
    txn++;
    $display("txn %0d rst_n=%0b code=%h vld=%0b -> exp idx=%0d ivld=%0b ill=%0b seq=%0b lock=%0b err=%0d",
             txn, r, c, v, m_index, m_vld, m_ill, m_seq, (m_mode == 2), m_err);
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      check("index",     int'(index),     m_index);
      check("index_vld", int'(index_vld), int'(m_vld));
      check("illegal",   int'(illegal),   int'(m_ill));
      check("seq_err",   int'(seq_err),   int'(m_seq));
      check("locked",    int'(locked),    int'(m_mode == 2));
      check("err_cnt",   int'(err_cnt),   m_err);
    end
  end

  int cur;

  initial begin
    // Reset for two cycles, then release into idle.
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    step(1, 8'h00, 0);
    #1;
    check("pin_reset_index",  int'(index),   0);
    check("pin_reset_locked", int'(locked),  0);
    check("pin_reset_err",    int'(err_cnt), 0);

    // Full sequence 0..15 then wrap to 0.
    for (int k = 0; k <= NS; k++) begin
      step(1, code_of(k % NS), 1);
      #1;
      if (k == 2) check("pin_lock_after_3", int'(locked), 1);
    end
    check("pin_wrap_index",  int'(index),   0);
    check("pin_wrap_locked", int'(locked),  1);
    check("pin_wrap_err",    int'(err_cnt), 0);

    // Locked at index 5, then an illegal code.
    for (int k = 1; k <= 5; k++) step(1, code_of(k), 1);
    step(1, 8'h05, 1);
    #1;
    check("pin_ill_illegal", int'(illegal), 1);
    check("pin_ill_seq",     int'(seq_err), 1);
    check("pin_ill_err",     int'(err_cnt), 1);
    check("pin_ill_locked",  int'(locked),  0);
    check("pin_ill_index",   int'(index),   5);

    // Relock to index 4, then a mid-run counter reset.
    for (int k = 0; k <= 4; k++) step(1, code_of(k), 1);
    step(1, 8'h00, 1);
    #1;
    check("pin_jump_seq",   int'(seq_err), 1);
    check("pin_jump_index", int'(index),   0);
    check("pin_jump_err",   int'(err_cnt), 2);
    step(1, 8'h01, 1);
    step(1, 8'h03, 1);
    #1;
    check("pin_relock_pending", int'(locked), 0);
    step(1, 8'h07, 1);
    #1;
    check("pin_relock", int'(locked), 1);

    // Stalled counter, then gapped valid.
    for (int i = 0; i < 5; i++) step(1, 8'h07, 1);
    for (int i = 0; i < 6; i++) step(1, 8'h07, (i % 2) == 0);
    #1;
    check("pin_stall_locked", int'(locked),  1);
    check("pin_stall_err",    int'(err_cnt), 2);

    // Randomised traffic: mostly advancing, with stalls, idles, jumps, junk.
    cur = 3;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        cur = (cur + 1) % NS;
        step(1, code_of(cur), 1);
      end else if (r < 65) begin
        step(1, code_of(cur), 1);
      end else if (r < 75) begin
        step(1, 8'($urandom), 0);
      end else if (r < 85) begin
        cur = $urandom_range(0, NS - 1);
        step(1, code_of(cur), 1);
      end else if (r < 98) begin
        step(1, 8'($urandom), 1);
      end else begin
        step(0, 8'($urandom), $urandom_range(0, 1));
      end
    end

    // Saturate the error counter, then clear it with reset.
    for (int i = 0; i < 300; i++) step(1, 8'h55, 1);
    #1;
    check("pin_sat_err", int'(err_cnt), 255);
    step(0, 8'h55, 1);
    #1;
    check("pin_clr_err",    int'(err_cnt), 0);
    check("pin_clr_locked", int'(locked),  0);
    step(1, 8'h00, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_counter_decoder.md
Name: shift_counter_decoder

Overview:
Receive-side companion to the 8-bit Johnson shift counter. Samples the counter's parallel code, converts it back to a binary state index, and flags codes that are not valid Johnson codes. A small lock FSM checks that successive codes advance by exactly one state. It reports sequence breaks and keeps a saturating error count for the bench and for the system monitor.

Parameters:
WIDTH, 8, Johnson code width; the sequence has 2*WIDTH states.
IDX_W, 4, index width, equal to $clog2(2*WIDTH).
LOCK_COUNT, 3, number of consecutive legal, correctly advancing codes needed to declare lock (minimum 2).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
code  input  WIDTH  Johnson code from the shift counter.
code_vld  input  1  code is sampled only in cycles where this is 1.
index  output  IDX_W  decoded state index, 0..2*WIDTH-1.
index_vld  output  1  one-cycle pulse: index was updated from a legal code.
illegal  output  1  one-cycle pulse: the sampled code was not a legal Johnson code.
seq_err  output  1  one-cycle pulse: lock was lost.
locked  output  1  FSM is in LOCKED.
err_cnt  output  ERR_W  saturating count of illegal and seq_err events.

Behaviour:
- Reset (reset==0 at a clk edge):
  - index=0, index_vld=0, illegal=0, seq_err=0, locked=0, err_cnt=0.
  - FSM goes to HUNT; run counter=0; prev_idx=0.
  - Reset overrides every other event in that cycle.
  - Reset during LOCKED does not count as an error.
- Legal code: the form 0..01..1 (including all-zeros) or 1..10..0 (including all-ones).
  - Every other pattern is illegal, e.g. 8'b00000101 or 8'b01111110.
- Decode, with p = popcount(code):
  - code[WIDTH-1]==0: index = p.
  - code[WIDTH-1]==1: index = 2*WIDTH - p.
  - Examples for WIDTH=8: 00000000->0, 00000111->3, 11111111->8, 11111110->9, 10000000->15.
- Latency: all outputs are registered one cycle after the code_vld sample.
  - On an illegal code, index holds its old value.
- Idle cycles: code_vld==0 causes no state change and no pulses; index holds.
- Each legal sample with code_vld==1:
  - Pulses index_vld.
  - Computes next_ok = (index == prev_idx+1 mod 2*WIDTH).
  - Computes same = (index == prev_idx).
- FSM states HUNT, CHECK, LOCKED. Evaluation order per sample: illegal first, then same, then next_ok.
- HUNT:
  - Legal code: go to CHECK, run=1.
  - Illegal code: stay in HUNT.
- CHECK:
  - Illegal code: go to HUNT.
  - same: no change (a stalled counter is allowed).
  - next_ok: run++; when run reaches LOCK_COUNT, go to LOCKED.
  - Any other legal code: run=1, stay in CHECK.
- LOCKED:
  - same or next_ok: stay in LOCKED.
  - Any other legal code: pulse seq_err, go to HUNT.
  - Illegal code: pulse both illegal and seq_err, go to HUNT.
- Wrap-around: index 15 -> 0 counts as next_ok.
- prev_idx updates on every legal sample.
- err_cnt increments by 1 per sample with illegal OR seq_err, so a simultaneous illegal+seq_err counts once.
  - Saturates at 2^ERR_W-1.
  - Cleared only by reset.
- locked=1 exactly while the FSM is in LOCKED, registered.

Decomposition:
- Package shift_counter_pkg holds:
  - the FSM state enum (HUNT, CHECK, LOCKED);
  - the default WIDTH/IDX_W constants, shared with shift_counter.
- One combinational sub-module, johnson_decode, is natural: input code, outputs legal and index. It is reusable for ring-code monitors.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Reset held low 2 cycles, then released with code=0 and code_vld=0 -> all outputs 0, locked=0.
- Drive the full Johnson sequence 0x00,0x01,0x03,...,0xFF,0xFE,...,0x80,0x00 with code_vld=1 each cycle -> index follows 0..15,0; locked rises 1 cycle after the 3rd sample; wrap 15->0 gives no seq_err; err_cnt=0.
- While locked at index 5 (0x1F), drive 0x05 -> 1 cycle later illegal=1, seq_err=1, err_cnt=1, locked=0, index stays 5.
- While locked at index 4, drive 0x00 (counter reset mid-run) -> seq_err=1, index=0, FSM to HUNT; then 0x01, 0x03 -> relocks after LOCK_COUNT samples.
- Hold code=0x07 with code_vld=1 for 5 cycles in LOCKED, then toggle code_vld 1/0 -> locked stays 1, index_vld pulses only on code_vld cycles, no errors.
- Force 300 illegal samples (0x55) -> err_cnt saturates at 255; an active-low reset then clears it to 0.
